spi_mem_responder: RTL
======================

# spi_mem_responder

SPI mode-0 memory responder: the device side of the serial memory protocol that the CPU's fetch controller initiates. It oversamples `cs`/`sclk`/`mosi` in the `clk` domain, decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address, and serves data from an internal byte-addressed RAM. It is used as the on-chip/bench memory model behind the instruction fetch path, and has a backdoor port for preload and inspection.

## Interface
- `ADDR_BITS`, default 6: RAM holds 2**ADDR_BITS bytes; upper address bits ignored.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock clk.
- `sclk`  in  1  SPI clock from the initiator (async to clk).
- `cs`  in  1  chip select, active-low (async).
- `mosi`  in  1  serial data from the initiator.
- `miso`  out  1  serial data to the initiator, MSB first.
- `busy`  out  1  high while a selected transaction is in progress (synchronized cs low).
- `load_en`  in  1  backdoor byte write strobe.
- `load_addr`  in  ADDR_BITS  backdoor address (read and write).
- `load_data`  in  8  backdoor write data.
- `dbg_data`  out  8  combinational RAM contents at `load_addr`.

## Operation
- Inputs pass through 2-flop synchronizers; rise/fall of synchronized sclk detected by comparing with a third flop.
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE: synchronized cs falls -> CMD, bit count 0, shift register cleared.
- CMD: shift mosi in on each sclk rise; after bit 8: 0x03 -> ADDR (read), 0x02 -> ADDR (write), anything else -> IGNORE.
- ADDR: shift 24 bits; after bit 24, address = low ADDR_BITS bits. Read: load mem[addr] into tx shifter, go READ. Write: go WRITE.
- READ: on each sclk fall, present the next tx bit on miso (the first fall after the last address bit presents bit 7 of mem[addr]). After 8 bits, addr+1 (mod 2**ADDR_BITS) and reload. A 32-bit initiator read returns mem[a] in bits 31:24 down to mem[a+3] in bits 7:0.
- WRITE: shift mosi on sclk rise; on the 8th bit, write the byte to mem[addr] and addr+1 (wrap). A partial byte at cs rise is discarded.
- IGNORE: no RAM access, miso 0, until cs rises.
- Synchronized cs rising in any state -> IDLE; miso 0; partial state discarded.
- miso is 0 whenever not in READ.
- Backdoor: load_en writes load_data to mem[load_addr] on the clk edge. If it coincides with an SPI byte write, both writes take place, except at the same address, where the backdoor write wins.
- Reset: state IDLE, miso 0, busy 0, counters/shifters 0. RAM contents are not reset. Reset mid-transaction abandons it; the block resumes only after a fresh cs falling edge. If cs is already low when reset releases, it is treated as IGNORE until cs goes high.

## Timing
- Sampling latency: 3 clk from a pin edge to the detected edge.
- sclk high and low phases must each be >= 4 clk; cs setup to the first sclk rise must be >= 4 clk. The fetch controller's sclk (8 clk per phase, cs delay 5 clk) satisfies this.
- miso updates 3-4 clk after the sclk fall and is stable through the following rise.
- busy follows synchronized cs with 2 clk latency.
- RAM write occurs on the clk cycle after the detected 8th data rise.

## Structure
- Shared package `spi_mem_pkg`: OPC_READ = 8'h03, OPC_WRITE = 8'h02, ADDR_FIELD_BITS = 24, responder state enum. The fetch controller uses the same opcodes.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for sclk. cs and mosi use plain synchronizers.

## Test plan
- Preload mem[4..7] = 0x13,0x05,0x50,0x00 via backdoor; issue READ 0x03 addr 0x000004 with 32 data clocks -> miso stream 0x13055000.
- WRITE 0x02 addr 0x00003E, data 0xAABBCCDD -> dbg_data reads 0xAA@0x3E, 0xBB@0x3F, 0xCC@0x00, 0xDD@0x01 (wraparound).
- Opcode 0x0B then 32 clocks -> miso stays 0, RAM unchanged, busy high until cs rises.
- WRITE with 12 data bits then cs high -> only the first byte is written, the next address is unchanged, and state returns to IDLE.
- Assert rst_n low for 2 clk during the READ data phase -> miso 0, busy 0. A subsequent full READ of 0x000004 returns correct data.
- Backdoor load and SPI byte write to the same address on the same clk -> RAM holds load_data.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the serial memory protocol: opcodes, address field
// width and the responder state encoding.
package spi_mem_pkg;

    localparam logic [7:0] OPC_READ        = 8'h03;
    localparam logic [7:0] OPC_WRITE       = 8'h02;
    localparam int         ADDR_FIELD_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } resp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall
// pulses derived from a third flop.
module spi_sync_edge (
    input  logic clk,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // No reset: the chain self-flushes within three cycles of any pin state.
    always_ff @(posedge clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
        r_prev <= r_sync;
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder: oversamples the serial pins in the clk domain,
// decodes READ/WRITE with a 24-bit address and serves a byte-addressed RAM.
module spi_mem_responder #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 busy,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic [7:0]           dbg_data
);

    import spi_mem_pkg::*;

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [7:0] r_mem [DEPTH];

    logic r_cs_meta;
    logic r_cs_sync;
    logic r_cs_prev;
    logic r_mosi_meta;
    logic r_mosi_sync;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    resp_state_t          r_state,     w_state_next;
    logic [4:0]           r_bit_cnt,   w_bit_cnt_next;
    logic [7:0]           r_shift,     w_shift_next;
    logic [ADDR_BITS-1:0] r_addr,      w_addr_next;
    logic                 r_is_write,  w_is_write_next;
    logic [7:0]           r_tx,        w_tx_next;
    logic [2:0]           r_tx_cnt,    w_tx_cnt_next;
    logic                 r_miso,      w_miso_next;
    logic                 r_wr_en,     w_wr_en_next;
    logic [ADDR_BITS-1:0] r_wr_addr,   w_wr_addr_next;
    logic [7:0]           r_wr_data,   w_wr_data_next;
    logic                 r_busy;

    logic [7:0]           w_shift_in;
    logic [ADDR_BITS-1:0] w_addr_in;
    logic [ADDR_BITS-1:0] w_addr_inc;

    spi_sync_edge u_sclk_sync (
        .clk    (clk),
        .i_d    (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // Pin synchronizers are left unreset so that a cs already low at reset
    // release is never mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        r_cs_meta   <= cs;
        r_cs_sync   <= r_cs_meta;
        r_cs_prev   <= r_cs_sync;
        r_mosi_meta <= mosi;
        r_mosi_sync <= r_mosi_meta;
    end

    assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
    assign w_cs_fall  = ~r_cs_sync & r_cs_prev;
    assign w_shift_in = {r_shift[6:0], r_mosi_sync};
    assign w_addr_in  = {r_addr[ADDR_BITS-2:0], r_mosi_sync};
    assign w_addr_inc = r_addr + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_addr_next     = r_addr;
        w_is_write_next = r_is_write;
        w_tx_next       = r_tx;
        w_tx_cnt_next   = r_tx_cnt;
        w_miso_next     = r_miso;
        w_wr_en_next    = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_wr_data_next  = r_wr_data;

        if (w_cs_rise) begin
            w_state_next    = ST_IDLE;
            w_bit_cnt_next  = '0;
            w_shift_next    = '0;
            w_addr_next     = '0;
            w_is_write_next = 1'b0;
            w_tx_next       = '0;
            w_tx_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_next   = ST_CMD;
                        w_bit_cnt_next = '0;
                        w_shift_next   = '0;
                    end else if (!r_cs_sync) begin
                        // Selected without a seen falling edge (e.g. after reset).
                        w_state_next = ST_IGNORE;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        w_shift_next   = w_shift_in;
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_next = '0;
                            w_shift_next   = '0;
                            if (w_shift_in == OPC_READ) begin
                                w_state_next    = ST_ADDR;
                                w_is_write_next = 1'b0;
                            end else if (w_shift_in == OPC_WRITE) begin
                                w_state_next    = ST_ADDR;
                                w_is_write_next = 1'b1;
                            end else begin
                                w_state_next = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        w_addr_next    = w_addr_in;
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'(ADDR_FIELD_BITS - 1)) begin
                            w_bit_cnt_next = '0;
                            if (r_is_write) begin
                                w_state_next = ST_WRITE;
                            end else begin
                                w_state_next  = ST_READ;
                                w_tx_next     = r_mem[w_addr_in];
                                w_tx_cnt_next = '0;
                            end
                        end
                    end
                end
                ST_READ: begin
                    if (w_sclk_fall) begin
                        w_miso_next   = r_tx[7];
                        w_tx_next     = {r_tx[6:0], 1'b0};
                        w_tx_cnt_next = r_tx_cnt + 3'd1;
                        if (r_tx_cnt == 3'd7) begin
                            w_addr_next = w_addr_inc;
                            w_tx_next   = r_mem[w_addr_inc];
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_sclk_rise) begin
                        w_shift_next   = w_shift_in;
                        w_bit_cnt_next = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_next = '0;
                            w_shift_next   = '0;
                            w_wr_en_next   = 1'b1;
                            w_wr_addr_next = r_addr;
                            w_wr_data_next = w_shift_in;
                            w_addr_next    = w_addr_inc;
                        end
                    end
                end
                ST_IGNORE: begin
                    w_state_next = ST_IGNORE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        if (w_state_next != ST_READ) begin
            w_miso_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_tx       <= '0;
            r_tx_cnt   <= '0;
            r_miso     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_addr     <= w_addr_next;
            r_is_write <= w_is_write_next;
            r_tx       <= w_tx_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_miso     <= w_miso_next;
            r_wr_en    <= w_wr_en_next;
            r_wr_addr  <= w_wr_addr_next;
            r_wr_data  <= w_wr_data_next;
            r_busy     <= ~r_cs_meta;
        end
    end

    // Backdoor write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign miso     = r_miso;
    assign busy     = r_busy;
    assign dbg_data = r_mem[load_addr];

endmodule
